// File: rtl/div3_arbiter.sv
// Two-requester round-robin arbiter feeding a shared
// digit-serial divisible-by-3 checker.
module div3_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_valid,
  input  logic [3:0] a_digit,
  input  logic       a_last,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [3:0] b_digit,
  input  logic       b_last,
  output logic       b_ready,
  output logic       res_valid,
  output logic       res_div,
  output logic       res_src,
  input  logic       res_ready
);

  typedef enum logic [1:0] {
    IDLE,
    RUN_A,
    RUN_B,
    RESULT
  } state_t;

  state_t     state;
  logic [1:0] r;
  logic       ptr;

  logic [3:0] digit;
  logic       last;
  logic       xfer;
  logic [4:0] sum;
  logic [4:0] s;
  logic [1:0] r_nxt;

  // owner's digit and the folded (r + digit) mod 3
  always_comb begin
    digit = a_digit;
    last  = a_last;
    if (state == RUN_B) begin
      digit = b_digit;
      last  = b_last;
    end
    xfer = (a_valid && a_ready) || (b_valid && b_ready);
    sum  = {3'd0, r} + {1'b0, digit};
    s    = sum;
    if (s >= 5'd9) s = s - 5'd9;
    if (s >= 5'd6) s = s - 5'd6;
    if (s >= 5'd3) s = s - 5'd3;
    r_nxt = (s == 5'd1) ? 2'd1 :
            (s == 5'd2) ? 2'd2 : 2'd0;
  end

  // arbitration FSM with registered handshake/result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      r         <= 2'd0;
      ptr       <= 1'b0;
      a_ready   <= 1'b0;
      b_ready   <= 1'b0;
      res_valid <= 1'b0;
      res_div   <= 1'b0;
      res_src   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_valid && (!b_valid || !ptr)) begin
            state   <= RUN_A;
            a_ready <= 1'b1;
          end else if (b_valid) begin
            state   <= RUN_B;
            b_ready <= 1'b1;
          end
        end
        RUN_A, RUN_B: begin
          if (xfer) begin
            r <= r_nxt;
            if (last) begin
              state     <= RESULT;
              a_ready   <= 1'b0;
              b_ready   <= 1'b0;
              res_valid <= 1'b1;
              res_div   <= (r_nxt == 2'd0);
              res_src   <= (state == RUN_B);
            end
          end
        end
        RESULT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            r         <= 2'd0;
            ptr       <= ~res_src;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div3_arbiter.sv
// Self-checking bench for div3_arbiter: directed
// scenarios plus randomized traffic vs a queue model.
module tb_div3_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, a_last, a_ready;
  logic [3:0] a_digit;
  logic       b_valid, b_last, b_ready;
  logic [3:0] b_digit;
  logic       res_valid, res_div, res_src;
  logic       res_ready;

  div3_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_digit   (a_digit),
    .a_last    (a_last),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_digit   (b_digit),
    .b_last    (b_last),
    .b_ready   (b_ready),
    .res_valid (res_valid),
    .res_div   (res_div),
    .res_src   (res_src),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  typedef enum int {P_IDLE, P_RUN, P_RES} ph_t;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] a_dig[$];
  bit         a_lst[$];
  logic [3:0] b_dig[$];
  bit         b_lst[$];
  bit         a_mid, b_mid;

  ph_t ph;
  bit  own, fav, exp_div;
  int  exp_len, cyc, stall;
  bit  last_div, last_src;
  int  bubble_pct = 0;
  int  rr_pct     = 100;
  int  hold_left  = 0;
  bit  obs_div[$];
  bit  obs_src[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic push_num(input bit src, input int d[$]);
    foreach (d[i]) begin
      if (!src) begin
        a_dig.push_back(4'(d[i]));
        a_lst.push_back(i == d.size() - 1);
      end else begin
        b_dig.push_back(4'(d[i]));
        b_lst.push_back(i == d.size() - 1);
      end
    end
  endtask

  // expected outcome of a requester's next number
  task automatic head_info(input bit src,
                           output bit div,
                           output int len);
    int s;
    s   = 0;
    len = 0;
    if (!src) begin
      for (int i = 0; i < a_dig.size(); i++) begin
        s += int'(a_dig[i]);
        len++;
        if (a_lst[i]) break;
      end
    end else begin
      for (int i = 0; i < b_dig.size(); i++) begin
        s += int'(b_dig[i]);
        len++;
        if (b_lst[i]) break;
      end
    end
    div = (s % 3 == 0);
  endtask

  task automatic model_reset();
    ph       = P_IDLE;
    fav      = 1'b0;
    last_div = 1'b0;
    last_src = 1'b0;
    a_mid    = 1'b0;
    b_mid    = 1'b0;
    a_dig.delete();
    a_lst.delete();
    b_dig.delete();
    b_lst.delete();
  endtask

  task automatic drive();
    a_valid = 1'b0;
    a_last  = 1'b0;
    a_digit = 4'($urandom);
    b_valid = 1'b0;
    b_last  = 1'b0;
    b_digit = 4'($urandom);
    if (a_dig.size() > 0 &&
        !(a_mid && $urandom_range(99) < bubble_pct)) begin
      a_valid = 1'b1;
      a_digit = a_dig[0];
      a_last  = a_lst[0];
    end
    if (b_dig.size() > 0 &&
        !(b_mid && $urandom_range(99) < bubble_pct)) begin
      b_valid = 1'b1;
      b_digit = b_dig[0];
      b_last  = b_lst[0];
    end
    if (hold_left > 0) res_ready = 1'b0;
    else res_ready = ($urandom_range(99) < rr_pct);
  endtask

  task automatic sample();
    bit l;
    case (ph)
      P_IDLE: begin
        chk("idle_a_ready", a_ready, 0);
        chk("idle_b_ready", b_ready, 0);
        chk("idle_res_valid", res_valid, 0);
        chk("idle_res_div", res_div, last_div);
        chk("idle_res_src", res_src, last_src);
        if (a_valid || b_valid) begin
          own   = (a_valid && (!b_valid || !fav)) ? 1'b0 : 1'b1;
          head_info(own, exp_div, exp_len);
          ph    = P_RUN;
          cyc   = 1;
          stall = 0;
        end
      end
      P_RUN: begin
        cyc++;
        chk("run_a_ready", a_ready, !own);
        chk("run_b_ready", b_ready, own);
        chk("run_res_valid", res_valid, 0);
        chk("run_res_div", res_div, last_div);
        chk("run_res_src", res_src, last_src);
        if (!own && a_valid) begin
          l = a_lst.pop_front();
          void'(a_dig.pop_front());
          a_mid = !l;
          if (l) ph = P_RES;
        end else if (own && b_valid) begin
          l = b_lst.pop_front();
          void'(b_dig.pop_front());
          b_mid = !l;
          if (l) ph = P_RES;
        end else begin
          stall++;
        end
      end
      default: begin
        cyc++;
        chk("res_valid", res_valid, 1);
        chk("res_a_ready", a_ready, 0);
        chk("res_b_ready", b_ready, 0);
        chk("res_div", res_div, exp_div);
        chk("res_src", res_src, own);
        if (res_ready) begin
          chk("latency", cyc, exp_len + 2 + stall);
          obs_div.push_back(res_div);
          obs_src.push_back(res_src);
          last_div = exp_div;
          last_src = own;
          fav      = !own;
          ph       = P_IDLE;
        end else begin
          stall++;
          if (hold_left > 0) hold_left--;
        end
      end
    endcase
  endtask

  // drain=1: stop once all digits are offered and taken
  task automatic run(input int limit, input bit drain);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      done = (a_dig.size() == 0) && (b_dig.size() == 0) &&
             (drain || ph == P_IDLE);
      if (done) break;
      @(posedge clk);
      #1 drive();
      @(negedge clk);
      sample();
    end
    done = (a_dig.size() == 0) && (b_dig.size() == 0) &&
           (drain || ph == P_IDLE);
    chk("timeout", done, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_div", res_div, 0);
    chk("rst_res_src", res_src, 0);
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    int n0;
    int d[$];
    reset     = 1'b1;
    a_valid   = 1'b0;
    a_digit   = 4'd0;
    a_last    = 1'b0;
    b_valid   = 1'b0;
    b_digit   = 4'd0;
    b_last    = 1'b0;
    res_ready = 1'b0;
    do_reset();

    push_num(1'b0, '{1, 2, 3});
    run(50, 1'b0);
    chk("a123_div", obs_div[$], 1);
    chk("a123_src", obs_src[$], 0);

    push_num(1'b1, '{7});
    run(50, 1'b0);
    chk("b7_div", obs_div[$], 0);
    chk("b7_src", obs_src[$], 1);

    do_reset();
    push_num(1'b0, '{4, 5});
    push_num(1'b1, '{1, 1});
    push_num(1'b0, '{4, 5});
    push_num(1'b1, '{1, 1});
    run(100, 1'b0);
    n0 = obs_src.size();
    chk("rr_src_order",
        {obs_src[n0-4], obs_src[n0-3],
         obs_src[n0-2], obs_src[n0-1]}, 4'b0101);
    chk("rr_div_order",
        {obs_div[n0-4], obs_div[n0-3],
         obs_div[n0-2], obs_div[n0-1]}, 4'b1010);

    hold_left = 5;
    push_num(1'b0, '{6});
    run(50, 1'b0);
    chk("hold_div", obs_div[$], 1);
    chk("hold_cnt", hold_left, 0);

    n0 = obs_div.size();
    push_num(1'b0, '{2, 2, 3});
    void'(a_lst.pop_back());
    void'(a_dig.pop_back());
    a_lst[1] = 1'b0;
    run(50, 1'b1);
    do_reset();
    push_num(1'b0, '{3});
    run(50, 1'b0);
    chk("abort_count", obs_div.size(), n0 + 1);
    chk("abort_div", obs_div[$], 1);

    push_num(1'b0, '{15, 10});
    run(50, 1'b0);
    chk("nonbcd_div", obs_div[$], 0);
    chk("nonbcd_src", obs_src[$], 0);

    bubble_pct = 30;
    rr_pct     = 60;
    for (int k = 0; k < 24; k++) begin
      d.delete();
      for (int j = 0; j < $urandom_range(5, 1); j++)
        d.push_back($urandom_range(15));
      push_num(k[0] ^ $urandom_range(1), d);
    end
    run(4000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div3_arbiter.md
DIV3_ARBITER -- requirements
Module: div3_arbiter

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 a_valid  in  1  requester A offers a digit.
REQ-005 a_digit  in  4  requester A digit, most-significant digit first.
REQ-006 a_last  in  1  A's digit is the final digit of its number.
REQ-007 a_ready  out  1  arbiter accepts A's digit this cycle.
REQ-008 b_valid  in  1  requester B offers a digit.
REQ-009 b_digit  in  4  requester B digit.
REQ-010 b_last  in  1  B's digit is the final digit.
REQ-011 b_ready  out  1  arbiter accepts B's digit this cycle.
REQ-012 res_valid  out  1  result available.
REQ-013 res_div  out  1  1 = completed number divisible by 3.
REQ-014 res_src  out  1  owner of the result: 0 = A, 1 = B.
REQ-015 res_ready  in  1  consumer takes the result.

Function
REQ-016 States SHALL be IDLE, RUN_A, RUN_B and RESULT; the single shared mod-3 residue register r is 2 bits wide.
REQ-017 In IDLE, a_ready, b_ready and res_valid SHALL be 0.
REQ-018 In IDLE, if only one of a_valid/b_valid is 1, that requester SHALL be granted: the next state is RUN_A or RUN_B.
REQ-019 In IDLE, if both are valid, the round-robin pointer SHALL decide the grant; the pointer favors A after reset.
REQ-020 With no valid in IDLE, the block SHALL stay in IDLE.
REQ-021 The grant cycle SHALL consume no digit, giving 1 cycle of arbitration latency.
REQ-022 In RUN_A, a_ready SHALL be 1 and b_ready 0; RUN_B is the mirror case.
REQ-023 A digit transfers when valid && ready, at up to one digit per cycle; the granted requester SHALL hold ownership until its last digit transfers.
REQ-024 On each transfer, r SHALL be updated to (r + digit) mod 3, with the digit taken as a 4-bit unsigned value.
REQ-025 Non-BCD codes 10..15 SHALL NOT be errors; they are reduced as their binary value mod 3.
REQ-026 When valid is low in a RUN state, r and the state SHALL hold.
REQ-027 On a transfer with last = 1, the next state SHALL be RESULT, with:
   - res_div = ((r + digit) mod 3 == 0);
   - res_src = owner.
REQ-028 A single-digit number (last on the first digit) SHALL be legal.
REQ-029 res_valid SHALL rise in the cycle after the last-digit transfer.
REQ-030 In RESULT, res_valid SHALL be 1 and res_div/res_src stable; both readies SHALL be 0.
REQ-031 RESULT SHALL hold until res_ready = 1.
REQ-032 On the res_valid && res_ready cycle:
   - the next state is IDLE;
   - r clears to 0;
   - the pointer moves to favor the requester not just served.
REQ-033 A requester not granted SHALL see ready = 0; it keeps its digit and valid asserted, with no loss or reorder.
REQ-034 Total latency for an N-digit number with continuous valid and res_ready = 1 SHALL be N+2 cycles from IDLE to the result handshake, with IDLE re-entered next.
REQ-035 res_div and res_src SHALL hold their last value outside RESULT; they are qualified only by res_valid.

Reset
REQ-036 While reset = 1 at a clock edge, the next state SHALL be:
   - state IDLE;
   - r = 0;
   - pointer favoring A;
   - a_ready = b_ready = 0;
   - res_valid = res_div = res_src = 0.
REQ-037 Reset SHALL take priority over all inputs.
REQ-038 Reset mid-number or in RESULT SHALL discard the partial residue and pending result, with no res_valid pulse afterwards.

Verification
REQ-039 A alone sends digits 1, 2, 3 (last 3), res_ready = 1 -> grant cycle, 3 accept cycles, then res_valid = 1 with res_div = 1, res_src = 0.
REQ-040 B alone sends 7 (last) -> res_valid with res_div = 0 (7 mod 3 = 1), res_src = 1.
REQ-041 A and B both valid from reset, A = 4,5 and B = 1,1, repeated twice -> service order A, B, A, B with results div = 1, 0, 1, 0; the waiting side's ready stays 0.
REQ-042 A sends 6 (last) with res_ready low for 5 cycles -> res_valid held 5+ cycles, outputs stable, a_ready = b_ready = 0, IDLE one cycle after res_ready rises.
REQ-043 A sends 2, 2 (no last) then reset for 1 cycle, then A sends 3 (last) -> no result for the aborted number; new result res_div = 1 (residue was cleared).
REQ-044 A sends 0xF, 0xA (last) -> (15 + 10) mod 3 = 1 -> res_div = 0; the accept pattern is unaffected by the non-BCD codes.
